data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU data-memory interface.
- Owns a 2^ADDR_W x DATA_W data RAM and services one read or write request at a time.
- Uses a valid/ready request handshake and a single-cycle response pulse after a fixed, parameterised access latency.
- Sits between the instruction interpreter's load/store port and the data storage, replacing the zero-latency combinational memory model.

Parameters:
- DATA_W, 16: word width in bits.
- ADDR_W, 8: address width; memory depth is 2^ADDR_W words.
- LATENCY, 2: cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- read_write_memory  input  1  0 = read, 1 = write; sampled on acceptance.
- addr  input  ADDR_W  word address; sampled on acceptance.
- data_out_memory  input  DATA_W  write data from the CPU; sampled on acceptance.
- data_in_memory  output  DATA_W  read data returned to the CPU.
- resp_valid  output  1  one-cycle pulse marking completion of the accepted request.
- resp_err  output  1  read parity error flag, qualified by resp_valid (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_err = 0, data_in_memory = 0, latency counter = 0.
  - RAM contents are not cleared by reset.
- Acceptance: a request is accepted at a rising edge where req_valid && req_ready.
  - On acceptance, latch read_write_memory, addr and data_out_memory into internal registers.
  - After acceptance, the input ports are don't-care until the next acceptance.
- State IDLE: req_ready = 1. On acceptance, load counter with LATENCY-1 and go to BUSY.
- State BUSY: req_ready = 0.
  - At each edge with counter != 0, decrement the counter.
  - At the edge with counter == 0, perform the access and return to IDLE.
  - The access is: a write stores the latched data to the latched address; a read loads data_in_memory from the latched address.
- Timing:
  - Call the acceptance edge E0. The access occurs at edge E0+LATENCY.
  - resp_valid is high for exactly the cycle following E0+LATENCY.
  - In that same cycle req_ready = 1, so a new request can be accepted at the next edge: back-to-back throughput is one request per LATENCY+1 cycles.
- Write response: resp_valid pulses; data_in_memory holds its previous value.
- Read response: data_in_memory updates with resp_valid and then holds until the next read response.
- Read after write to the same address returns the new data, because the write commits before the read is accepted.
- No out-of-range addresses exist; all 2^ADDR_W values are valid.
- req_valid asserted while BUSY is ignored. The requester must hold req_valid until it sees req_ready.
- Reset asserted mid-BUSY aborts the operation:
  - a pending write is not committed;
  - no resp_valid is produced;
  - after release the block is in IDLE.
- resp_err is 0 whenever resp_valid is 0.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Enabled:
  - each RAM word stores an extra even-parity bit, computed over data_out_memory at the write access;
  - on a read access, parity is recomputed over the stored data; on mismatch resp_err = 1 for the resp_valid cycle;
  - data_in_memory still returns the stored data on a mismatch;
  - an extra input port par_inject (1 bit), sampled on acceptance of a write, inverts the stored parity bit for test.
- Disabled: no parity storage, no par_inject port, resp_err tied to 0.

Test Plan:
- Reset then idle, LATENCY=2 → req_ready = 1, resp_valid = 0, data_in_memory = 0x0000, resp_err = 0.
- Write 0xBEEF to addr 0x12 accepted at E0, then read 0x12 → write resp_valid in cycle after E2; read accepted at E3; resp_valid with data_in_memory = 0xBEEF in cycle after E5.
- req_valid held high for 3 consecutive requests (write 0x01 = 0x0001, write 0xFF = 0xFFFF, read 0xFF) → accepted every 3 cycles, req_ready low during BUSY, final read returns 0xFFFF.
- Write 0x5555 to 0x40, read 0x40, then write 0x1234 to 0x41 → data_in_memory stays 0x5555 through the write response.
- Write 0xAAAA to 0x20, then assert rst_n = 0 one cycle after accepting a write of 0x0000 to 0x20 → no resp_valid; after release, read 0x20 returns 0xAAAA.
- MEM_PARITY_EN: write 0x0F0F to 0x33 with par_inject = 1, then read 0x33 → data_in_memory = 0x0F0F, resp_err = 1; rewrite with par_inject = 0 and read → resp_err = 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data RAM responder with valid/ready request and one-cycle response pulse.
// Optional read parity checking with par_inject test port when MEM_PARITY_EN is defined.
module data_mem_responder #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              read_write_memory,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_out_memory,
`ifdef MEM_PARITY_EN
  input  logic              par_inject,
`endif
  output logic [DATA_W-1:0] data_in_memory,
  output logic              resp_valid,
  output logic              resp_err
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, next_state;
  logic [3:0]        cnt;
  logic              accept, do_access;
  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_word;
  logic [WORD_W-1:0] wr_word;

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      if (accept)
        cnt <= 4'(LATENCY - 1);
      else if (state == BUSY && cnt != 4'd0)
        cnt <= cnt - 4'd1;
    end
  end

`ifdef MEM_PARITY_EN
  logic lat_inj;
  assign wr_word = {(^lat_data) ^ lat_inj, lat_data};
`else
  assign wr_word = lat_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rw   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
`ifdef MEM_PARITY_EN
      lat_inj  <= 1'b0;
`endif
    end else if (accept) begin
      lat_rw   <= read_write_memory;
      lat_addr <= addr;
      lat_data <= data_out_memory;
`ifdef MEM_PARITY_EN
      lat_inj  <= par_inject;
`endif
    end
  end

  // RAM is not reset; reset forces IDLE, so an in-flight write never commits.
  always_ff @(posedge clk) begin
    if (do_access && lat_rw)
      mem[lat_addr] <= wr_word;
  end

  assign rd_word = mem[lat_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid     <= 1'b0;
      data_in_memory <= '0;
    end else begin
      resp_valid <= do_access;
      if (do_access && !lat_rw)
        data_in_memory <= rd_word[DATA_W-1:0];
    end
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      resp_err <= 1'b0;
    else
      resp_err <= do_access && !lat_rw && ((^rd_word[DATA_W-1:0]) != rd_word[DATA_W]);
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder against an array memory model.
module tb_data_mem_responder;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              read_write_memory = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data_out_memory = '0;
  logic              par_inject = 1'b0;
  logic [DATA_W-1:0] data_in_memory;
  logic              resp_valid;
  logic              resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] model_mem [2**ADDR_W];
  logic              model_bad [2**ADDR_W];
  bit                written   [2**ADDR_W];
  logic [DATA_W-1:0] last_rd = '0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .read_write_memory(read_write_memory),
    .addr(addr),
    .data_out_memory(data_out_memory),
`ifdef MEM_PARITY_EN
    .par_inject(par_inject),
`endif
    .data_in_memory(data_in_memory),
    .resp_valid(resp_valid),
    .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of the response cycle.
  task automatic run_req(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic inj, input bit hold, input bit expect_now);
    int waited = 0;
    logic [DATA_W-1:0] exp_data;
    logic              exp_err;
    read_write_memory = rw;
    addr              = a;
    data_out_memory   = d;
    par_inject        = inj;
    req_valid         = 1'b1;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (expect_now) chk("accept_immediate", 32'(waited), 32'd0);
    if (waited >= 20) begin
      chk("accept_timeout", 32'(waited), 32'd0);
      return;
    end
    if (rw) begin
      model_mem[a] = d;
      model_bad[a] = inj;
      written[a]   = 1'b1;
      exp_data     = last_rd;
      exp_err      = 1'b0;
    end else begin
      exp_data = model_mem[a];
      exp_err  = model_bad[a];
      last_rd  = exp_data;
    end
    for (int n = 1; n <= LATENCY + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (!hold) req_valid = 1'b0;
        read_write_memory = 1'($urandom);
        addr              = ADDR_W'($urandom);
        data_out_memory   = DATA_W'($urandom);
        par_inject        = 1'($urandom);
      end
      if (n <= LATENCY) begin
        chk("busy_ready_low", 32'(req_ready), 32'd0);
        chk("busy_no_resp", 32'(resp_valid), 32'd0);
      end else begin
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_ready", 32'(req_ready), 32'd1);
        chk(rw ? "wr_data_hold" : "rd_data", 32'(data_in_memory), 32'(exp_data));
        chk("resp_err", 32'(resp_err), 32'(exp_err));
      end
    end
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(negedge clk);
    chk("pulse_one_cycle", 32'(resp_valid), 32'd0);
    chk("idle_err", 32'(resp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      model_mem[i] = '0;
      model_bad[i] = 1'b0;
      written[i]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_resp", 32'(resp_valid), 32'd0);
    chk("idle_data", 32'(data_in_memory), 32'h0000);
    chk("idle_err", 32'(resp_err), 32'd0);

    // Write then read back-to-back
    run_req(1'b1, 8'h12, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    run_req(1'b0, 8'h12, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // req_valid held across three requests
    run_req(1'b1, 8'h01, 16'h0001, 1'b0, 1'b1, 1'b1);
    run_req(1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    run_req(1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // Read data holds through a later write response
    run_req(1'b1, 8'h40, 16'h5555, 1'b0, 1'b0, 1'b1);
    run_req(1'b0, 8'h40, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_req(1'b1, 8'h41, 16'h1234, 1'b0, 1'b0, 1'b1);
    idle_cycle();

    // Reset during BUSY aborts a pending write
    run_req(1'b1, 8'h20, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    read_write_memory = 1'b1;
    addr              = 8'h20;
    data_out_memory   = 16'h0000;
    par_inject        = 1'b0;
    req_valid         = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_rst_resp", 32'(resp_valid), 32'd0);
    chk("abort_rst_ready", 32'(req_ready), 32'd1);
    chk("abort_rst_data", 32'(data_in_memory), 32'h0000);
    rst_n   = 1'b1;
    last_rd = '0;
    for (int i = 0; i < LATENCY + 2; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    run_req(1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 1'b1);

`ifdef MEM_PARITY_EN
    run_req(1'b1, 8'h33, 16'h0F0F, 1'b1, 1'b0, 1'b1);
    run_req(1'b0, 8'h33, 16'h0000, 1'b0, 1'b0, 1'b1);
    run_req(1'b1, 8'h33, 16'h0F0F, 1'b0, 1'b0, 1'b1);
    run_req(1'b0, 8'h33, 16'h0000, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic over a small address window so reads hit written words
    for (int k = 0; k < 60; k++) begin
      logic              rw;
      logic [ADDR_W-1:0] a;
      logic              inj;
      bit                hold;
      rw   = 1'($urandom);
      a    = ADDR_W'($urandom_range(0, 15));
      if (!rw && !written[a]) rw = 1'b1;
`ifdef MEM_PARITY_EN
      inj  = 1'($urandom);
`else
      inj  = 1'b0;
`endif
      hold = ($urandom_range(0, 2) == 0);
      run_req(rw, a, DATA_W'($urandom), inj, hold, 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
